fix_to_fp_11_6: RTL and testbench
=================================

Name: fix_to_fp_11_6

Overview:
- Pipelined encoder: converts signed two's-complement fixed-point samples into the 20-bit FloPoCo FP(wE=11, wF=6) word.
- Feeds the FP comparators and subtractors of the ray-AABB datapath, which decode the same word.
- Word layout: [19:18] exception (00 zero, 01 normal, 10 inf, 11 NaN), [17] sign, [16:6] biased exponent (bias 1023), [5:0] fraction.
- Valid/ready streaming on both sides; 3-cycle latency; one result per cycle when not stalled.

Parameters:
- IN_W, 24, input width in bits, signed two's complement; legal range 8..64.
- FRAC_BITS, 12, input binary-point position; input value = in_data / 2^FRAC_BITS.
- WE, 11, exponent width; fixed by the datapath format, not to be overridden.
- WF, 6, fraction width; fixed, not to be overridden.

Ports:
- clk, input, 1, clock, rising edge.
- rst, input, 1, reset, asynchronous, active-high.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, the block accepts in_data this cycle.
- in_data, input, IN_W, signed fixed-point sample.
- out_valid, output, 1, out_fp is valid.
- out_ready, input, 1, the downstream block accepts out_fp.
- out_fp, output, 20, FloPoCo FP(11,6) word.

Behaviour:
- Reset values: out_valid=0, out_fp=0; all stage valid bits 0. in_ready is combinational and reads 1 during and after reset.
- Advance enable: adv = out_ready | ~out_valid; in_ready = adv.
  - A transfer occurs on a cycle where valid & ready are both high, at either end.
  - When adv=0 every stage holds its data and its valid bit. Bubbles are not compressed.
  - out_fp stays stable while out_valid=1 and out_ready=0.
- S1 (registered on adv):
  - sign = in_data[IN_W-1].
  - Magnitude is |in_data| in IN_W unsigned bits. The most negative input gives 2^(IN_W-1) without overflow.
  - zero flag = (in_data == 0).
- S2:
  - Leading-one position p is taken from 0..IN_W-1.
  - Magnitude is left-normalised so the leading one sits at the MSB.
  - Extract the WF fraction bits, a guard bit, and a sticky bit (OR of all lower bits).
  - Pre-exponent = p - FRAC_BITS + 1023, computed in 12 bits.
- S3: round to nearest, ties to even.
  - Increment when guard & (sticky | frac_lsb).
  - If the fraction carries out, fraction = 0 and exponent + 1.
  - Pack as {2'b01, sign, exp[10:0], frac}.
  - A zero input packs as 20'h00000, with sign forced to 0.
  - No inf or NaN is ever produced: the exponent range 1023±64 cannot overflow.
- When p < WF, the fraction is zero-padded on the right; guard = sticky = 0.
- Latency: an input accepted at cycle N appears on out_valid at cycle N+3 when adv stays 1.
- Reset mid-operation clears all in-flight samples immediately; none is emitted after rst deasserts.
- in_valid=0 while adv=1 inserts a bubble: the S1 valid bit is cleared and data registers may hold.

Decomposition:
- Shared package fp_11_6_pkg holds:
  - constants WE=11, WF=6, FP_W=20, BIAS=1023;
  - exception codes EXC_ZERO=2'b00, EXC_NORM=2'b01, EXC_INF=2'b10, EXC_NAN=2'b11;
  - field bit-position constants.
- Comparators and future FP blocks import the same package.
- One sub-module: lzc_norm, a combinational leading-zero count plus normalising shifter parameterised by IN_W. It is instantiated in S2.
- All pipeline registers and handshake logic stay in the top module.

Test Plan:
- Exact values, IN_W=24, FRAC_BITS=12, out_ready=1:
  - 24'h001000 (1.0) -> 20'h4FFC0.
  - 24'hFFE800 (-1.5) -> 20'h6FFE0.
  - 24'h000000 -> 20'h00000.
  - 24'h800000 (most negative) -> 20'h70280.
  - Each appears exactly 3 cycles after acceptance.
- Rounding:
  - 24'h001FF0 (round-up with carry) -> 20'h50000.
  - 24'h001020 (tie, even) -> 20'h4FFC0.
  - 24'h001060 (tie, odd -> up) -> 20'h4FFC2.
- Back-pressure:
  - Stream 6 samples back-to-back, drop out_ready for 4 cycles mid-stream.
  - in_ready must fall in the same cycle out_ready falls while out_valid=1.
  - out_fp is held stable during the stall.
  - All 6 results are delivered in order with no loss or duplication.
- Bubbles: alternate in_valid 1/0 -> out_valid alternates with the same 3-cycle offset; the values match the reference model.
- Reset mid-flight:
  - Accept 3 samples, assert rst for 1 cycle on the next cycle.
  - out_valid=0 and out_fp=0 immediately, and no stale result appears afterwards.
  - The next accepted sample emerges after 3 cycles.
- Random: 10k random in_data with random out_ready -> bit-exact against a software model, cross-checked by feeding pairs into the greater_or_equal comparator versus integer comparison.

Source files
------------

// File: rtl/fp_11_6_pkg.sv
// Shared FloPoCo FP(wE=11, wF=6) word definitions for the ray-AABB datapath.
// Converters, comparators and subtractors all pack/unpack through this package.
package fp_11_6_pkg;

  localparam int WE   = 11;
  localparam int WF   = 6;
  localparam int FP_W = 2 + 1 + WE + WF;
  localparam int BIAS = 1023;

  typedef enum logic [1:0] {
    EXC_ZERO = 2'b00,
    EXC_NORM = 2'b01,
    EXC_INF  = 2'b10,
    EXC_NAN  = 2'b11
  } exc_e;

  localparam int FRAC_LSB = 0;
  localparam int EXP_LSB  = FRAC_LSB + WF;
  localparam int SIGN_POS = EXP_LSB + WE;
  localparam int EXC_LSB  = SIGN_POS + 1;

  function automatic logic [FP_W-1:0] fp_pack(
    input exc_e            exc,
    input logic            sign,
    input logic [WE-1:0]   exp,
    input logic [WF-1:0]   frac
  );
    logic [FP_W-1:0] w;
    w = '0;
    w[EXC_LSB +: 2]   = exc;
    w[SIGN_POS]       = sign;
    w[EXP_LSB +: WE]  = exp;
    w[FRAC_LSB +: WF] = frac;
    return w;
  endfunction

endpackage

// File: rtl/fix_to_fp_11_6_lzc_norm.sv
// Combinational leading-zero count and left-normalising shifter.
// norm drops the leading one, so it carries only the bits below the MSB.
module lzc_norm #(
  parameter int IN_W = 24,
  parameter int LZ_W = $clog2(IN_W + 1)
) (
  input  logic [IN_W-1:0] mag,
  output logic [LZ_W-1:0] lz,
  output logic [IN_W-2:0] norm
);

  // One-hot marker of the leading one; no chained terms between bits.
  logic [IN_W-1:0] lead;

  for (genvar gi = 0; gi < IN_W; gi++) begin : g_lead
    assign lead[gi] = mag[gi] & ((mag >> (gi + 1)) == '0);
  end

  always_comb begin
    lz = LZ_W'(IN_W);
    for (int i = 0; i < IN_W; i++) begin
      if (lead[i]) lz = LZ_W'(IN_W - 1 - i);
    end
  end

  assign norm = (IN_W - 1)'(mag << lz);

endmodule

// File: rtl/fix_to_fp_11_6.sv
// Three-stage fixed-point to FP(11,6) encoder with valid/ready on both sides.
// All stages advance together on adv; bubbles travel with the data.
module fix_to_fp_11_6
  import fp_11_6_pkg::*;
#(
  parameter int IN_W      = 24,
  parameter int FRAC_BITS = 12,
  parameter int WE        = fp_11_6_pkg::WE,
  parameter int WF        = fp_11_6_pkg::WF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] out_fp
);

  localparam int LZ_W  = $clog2(IN_W + 1);
  localparam int LOW_W = IN_W - WF - 2;

  logic adv;

  // Stage 1: sign / magnitude split
  logic            s1_valid_reg, s1_sign_reg, s1_zero_reg;
  logic [IN_W-1:0] s1_mag_reg;
  logic [IN_W-1:0] s1_mag_next;

  // Stage 2: normalised fields
  logic            s2_valid_reg, s2_sign_reg, s2_zero_reg;
  logic [WF-1:0]   s2_frac_reg;
  logic            s2_guard_reg, s2_sticky_reg;
  logic [WE:0]     s2_exp_reg;

  logic [LZ_W-1:0] lz;
  logic [IN_W-2:0] norm;
  logic [WF-1:0]   s2_frac_next;
  logic            s2_guard_next, s2_sticky_next;
  logic [WE:0]     s2_exp_next;

  // Stage 3: rounded and packed word
  logic            s3_valid_reg;
  logic [FP_W-1:0] s3_fp_reg;

  logic            round_up, carry;
  logic [WF-1:0]   frac_rnd;
  logic [WE:0]     exp_rnd;
  logic [FP_W-1:0] s3_fp_next;

  assign adv       = out_ready | ~s3_valid_reg;
  assign in_ready  = adv;
  assign out_valid = s3_valid_reg;
  assign out_fp    = s3_fp_reg;

  // Most negative input wraps to 2^(IN_W-1), which is the correct unsigned magnitude.
  assign s1_mag_next = in_data[IN_W-1] ? (~in_data + IN_W'(1)) : in_data;

  lzc_norm #(
    .IN_W (IN_W),
    .LZ_W (LZ_W)
  ) u_lzc_norm (
    .mag  (s1_mag_reg),
    .lz   (lz),
    .norm (norm)
  );

  assign s2_frac_next  = norm[IN_W-2 -: WF];
  assign s2_guard_next = norm[IN_W-2-WF];
  assign s2_exp_next   = (WE + 1)'(IN_W - 1 - FRAC_BITS + BIAS) - (WE + 1)'(lz);

  if (LOW_W > 0) begin : g_sticky
    assign s2_sticky_next = |norm[LOW_W-1:0];
  end else begin : g_no_sticky
    assign s2_sticky_next = 1'b0;
  end

  assign round_up          = s2_guard_reg & (s2_sticky_reg | s2_frac_reg[0]);
  assign {carry, frac_rnd} = {1'b0, s2_frac_reg} + (WF + 1)'(round_up);
  assign exp_rnd           = s2_exp_reg + (WE + 1)'(carry);

  always_comb begin
    s3_fp_next = fp_pack(EXC_NORM, s2_sign_reg, exp_rnd[WE-1:0], frac_rnd);
    if (s2_zero_reg) begin
      s3_fp_next = fp_pack(EXC_ZERO, 1'b0, '0, '0);
    end else if (exp_rnd[WE]) begin
      // Unreachable for legal IN_W/FRAC_BITS; saturate rather than wrap.
      s3_fp_next = fp_pack(EXC_INF, s2_sign_reg, '0, '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_sign_reg   <= 1'b0;
      s1_zero_reg   <= 1'b0;
      s1_mag_reg    <= '0;
      s2_valid_reg  <= 1'b0;
      s2_sign_reg   <= 1'b0;
      s2_zero_reg   <= 1'b0;
      s2_frac_reg   <= '0;
      s2_guard_reg  <= 1'b0;
      s2_sticky_reg <= 1'b0;
      s2_exp_reg    <= '0;
      s3_valid_reg  <= 1'b0;
      s3_fp_reg     <= '0;
    end else if (adv) begin
      s1_valid_reg  <= in_valid;
      s1_sign_reg   <= in_data[IN_W-1];
      s1_zero_reg   <= (in_data == '0);
      s1_mag_reg    <= s1_mag_next;
      s2_valid_reg  <= s1_valid_reg;
      s2_sign_reg   <= s1_sign_reg;
      s2_zero_reg   <= s1_zero_reg;
      s2_frac_reg   <= s2_frac_next;
      s2_guard_reg  <= s2_guard_next;
      s2_sticky_reg <= s2_sticky_next;
      s2_exp_reg    <= s2_exp_next;
      s3_valid_reg  <= s2_valid_reg;
      s3_fp_reg     <= s3_fp_next;
    end
  end

endmodule

// File: tb/tb_fix_to_fp_11_6.sv
// Bench for fix_to_fp_11_6: exact-value table, latency, back-pressure, bubbles,
// reset mid-flight and a random stream checked through a scoreboard queue.
module tb_fix_to_fp_11_6;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [23:0] in_data;
  logic [19:0] out_fp;
  logic [19:0] in_exp;

  always #5 clk = ~clk;

  fix_to_fp_11_6 #(.IN_W(24), .FRAC_BITS(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fp    (out_fp)
  );

  typedef struct {
    logic [23:0] din;
    logic [19:0] fp;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[7];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_out   = 0;
  logic [23:0] prev_din;
  logic [19:0] prev_fp;
  bit          have_prev = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, want);
  endfunction

  // Reference: integer round-to-nearest-even on the magnitude.
  function automatic logic [19:0] model(input logic [23:0] d);
    longint v, mag, mant, rem, half;
    int     p, sh, e;
    logic   s;
    s   = d[23];
    v   = longint'($signed(d));
    mag = s ? -v : v;
    if (mag == 0) return 20'h00000;
    p = 0;
    for (int i = 0; i < 40; i++) if (mag[i]) p = i;
    if (p >= 6) begin
      sh   = p - 6;
      mant = mag >> sh;
      rem  = mag - (mant << sh);
      if (sh > 0) begin
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && mant[0])) mant = mant + 1;
      end
    end else begin
      mant = mag << (6 - p);
    end
    if (mant == 128) begin
      mant = 64;
      p    = p + 1;
    end
    e = p - 12 + 1023;
    return {2'b01, s, 11'(e), 6'(mant - 64)};
  endfunction

  function automatic longint fp_key(input logic [19:0] w);
    longint k;
    if (w[19:18] == 2'b00) return 0;
    k = longint'({w[16:6], w[5:0]});
    return w[17] ? -k : k;
  endfunction

  function automatic logic fp_ge(input logic [19:0] a, input logic [19:0] b);
    return fp_key(a) >= fp_key(b);
  endfunction

  function automatic logic [23:0] rand_din();
    logic [23:0] d;
    case ($urandom_range(0, 63))
      0:       d = 24'h000000;
      1:       d = 24'h800000;
      default: d = 24'($signed($urandom) >>> $urandom_range(0, 23));
    endcase
    return d;
  endfunction

  // Scoreboard: push on acceptance, pop and compare on delivery.
  always @(negedge clk) begin
    vec_t e;
    if (rst) begin
      sb_q.delete();
      have_prev = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got %h, expected no output", out_fp);
        end else begin
          e = sb_q.pop_front();
          n_out++;
          check($sformatf("out_fp[%0d] din=%h", n_out, e.din), 32'(out_fp), 32'(e.fp));
          if (have_prev && $signed(prev_din) >= $signed(e.din))
            check("fp_ge_vs_int", 32'(fp_ge(prev_fp, out_fp)), 32'd1);
          prev_din  = e.din;
          prev_fp   = out_fp;
          have_prev = 1;
        end
      end
      if (in_valid && in_ready) sb_q.push_back('{in_data, in_exp});
    end
  end

  task automatic step(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    int k;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    k = 0;
    while (sb_q.size() > 0 && k < 50) begin
      step(acc);
      k++;
    end
    if (sb_q.size() > 0) begin
      n_total++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb_q.size());
    end
  endtask

  task automatic measure_one(input logic [23:0] d, input logic [19:0] f, input string name);
    bit acc;
    int lat;
    out_ready = 1'b1;
    in_data   = d;
    in_exp    = f;
    in_valid  = 1'b1;
    step(acc);
    in_valid = 1'b0;
    check({name, "_accept"}, 32'(acc), 32'd1);
    lat = 1;
    while (!out_valid && lat < 10) begin
      step(acc);
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd3);
    step(acc);
  endtask

  initial begin
    bit          acc;
    int          idx, n0, seen, sent, cyc;
    logic [19:0] held;
    logic [23:0] bp_data[6];
    bit          hist[16];

    tbl[0] = '{24'h001000, 20'h4FFC0};
    tbl[1] = '{24'hFFE800, 20'h6FFE0};
    tbl[2] = '{24'h000000, 20'h00000};
    tbl[3] = '{24'h800000, 20'h70280};
    tbl[4] = '{24'h001FF0, 20'h50000};
    tbl[5] = '{24'h001020, 20'h4FFC0};
    tbl[6] = '{24'h001060, 20'h4FFC2};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_exp = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_fp",    32'(out_fp),    32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 7; i++) measure_one(tbl[i].din, tbl[i].fp, $sformatf("tbl%0d", i));

    // Back-pressure: 6 back-to-back samples, out_ready low for 4 cycles.
    for (int i = 0; i < 6; i++) bp_data[i] = rand_din();
    idx = 0; n0 = n_out; held = '0;
    for (int c = 0; c < 25; c++) begin
      out_ready = !(c >= 3 && c < 7);
      in_valid  = (idx < 6);
      in_data   = bp_data[idx < 6 ? idx : 5];
      in_exp    = model(in_data);
      #1;
      if (c == 3) begin
        check("bp_out_valid_at_stall", 32'(out_valid), 32'd1);
        check("bp_in_ready_falls",     32'(in_ready),  32'd0);
        held = out_fp;
      end
      if (c > 3 && c < 7) check($sformatf("bp_hold_c%0d", c), 32'(out_fp), 32'(held));
      step(acc);
      if (acc) idx++;
    end
    drain();
    check("bp_all_sent",      32'(idx),         32'd6);
    check("bp_all_delivered", 32'(n_out - n0),  32'd6);

    // Bubbles: alternate in_valid, out_valid follows 3 cycles later.
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      in_valid = (c % 2 == 0);
      in_data  = rand_din();
      in_exp   = model(in_data);
      #1;
      if (c >= 3) check($sformatf("bubble_valid_c%0d", c), 32'(out_valid), 32'(hist[c-3]));
      hist[c] = in_valid;
      step(acc);
    end
    drain();

    // Reset mid-flight.
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = rand_din();
      in_exp   = model(in_data);
      step(acc);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_fp",    32'(out_fp),    32'd0);
    step(acc);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      step(acc);
      if (out_valid) seen++;
    end
    check("midrst_no_stale", 32'(seen), 32'd0);
    measure_one(24'hFFF000, model(24'hFFF000), "post_rst");
    drain();

    // Random stream with random back-pressure.
    sent = 0; cyc = 0; in_valid = 1'b0;
    while (sent < 10000 && cyc < 40000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_data  = rand_din();
        in_exp   = model(in_data);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step(acc);
      cyc++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    if (sent < 10000) begin
      n_total++;
      $display("FAIL random_timeout: got %0d sent, expected 10000", sent);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
